// File: rtl/poly_player_pkg.sv
// Shared constants and helpers for the polyphonic note player.
package poly_player_pkg;

  localparam logic WAVE_SAW    = 1'b0;
  localparam logic WAVE_SQUARE = 1'b1;

  // Voice index width; a single-voice build still carries a 1-bit select.
  function automatic int voice_idx_w(input int n_voices);
    return (n_voices > 1) ? $clog2(n_voices) : 1;
  endfunction

  function automatic int square_amp(input int sample_w);
    return (1 << (sample_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/voice_channel.sv
// One voice: phase accumulator, beat-counted duration, load/beat priority and
// waveform stage. The registered sample updates only on an accepted frame.
module voice_channel
  import poly_player_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int PHASE_W  = 20,
  parameter int DUR_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                beat,
  input  logic                frame_accept,
  input  logic                load,
  input  logic [PHASE_W-1:0]  load_step,
  input  logic                load_wave,
  input  logic [DUR_W-1:0]    load_duration,
  output logic                active,
  output logic                done,
  output logic [SAMPLE_W-1:0] sample
);

  localparam logic [SAMPLE_W-1:0] SQ_POS = SAMPLE_W'(square_amp(SAMPLE_W));
  localparam logic [SAMPLE_W-1:0] SQ_NEG = SAMPLE_W'(-square_amp(SAMPLE_W));

  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  step_q, step_d;
  logic                wave_q, wave_d;
  logic [DUR_W-1:0]    rem_q, rem_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] p;
  logic [SAMPLE_W-1:0] wave_val;

  always_comb begin
    p = phase_q[PHASE_W-1 -: SAMPLE_W];
    if (wave_q == WAVE_SQUARE) begin
      wave_val = p[SAMPLE_W-1] ? SQ_NEG : SQ_POS;
    end else begin
      wave_val = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
    end
  end

  // A load overrides any beat or phase advance for this voice in the same cycle.
  always_comb begin
    phase_d  = phase_q;
    step_d   = step_q;
    wave_d   = wave_q;
    rem_d    = rem_q;
    active_d = active_q;
    done_d   = 1'b0;
    sample_d = sample_q;
    if (frame_accept) begin
      sample_d = (active_q && play_enable) ? wave_val : '0;
    end
    if (load) begin
      step_d   = load_step;
      wave_d   = load_wave;
      rem_d    = load_duration;
      phase_d  = '0;
      active_d = |load_duration;
    end else if (active_q && play_enable) begin
      if (frame_accept) begin
        phase_d = phase_q + step_q;
      end
      if (beat) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == DUR_W'(1)) begin
          active_d = 1'b0;
          phase_d  = '0;
          done_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= '0;
      step_q   <= '0;
      wave_q   <= 1'b0;
      rem_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      phase_q  <= phase_d;
      step_q   <= step_d;
      wave_q   <= wave_d;
      rem_q    <= rem_d;
      active_q <= active_d;
      done_q   <= done_d;
      sample_q <= sample_d;
    end
  end

  assign active = active_q;
  assign done   = done_q;
  assign sample = sample_q;

endmodule

// File: rtl/poly_note_player.sv
// N-voice note player: voice bank, adder tree, reduction and output strobe.
// POLY_PLAYER_SATURATE_EN selects saturation of the sum; otherwise it is shifted down.
module poly_note_player
  import poly_player_pkg::*;
#(
  parameter int N_VOICES = 4,
  parameter int SAMPLE_W = 16,
  parameter int PHASE_W  = 20,
  parameter int DUR_W    = 6,
  localparam int VOICE_IDX_W = voice_idx_w(N_VOICES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play_enable,
  input  logic                   beat,
  input  logic                   new_frame,
  input  logic                   note_load,
  input  logic [VOICE_IDX_W-1:0] note_voice,
  input  logic [PHASE_W-1:0]     note_step,
  input  logic                   note_wave,
  input  logic [DUR_W-1:0]       note_duration,
  output logic [N_VOICES-1:0]    voice_active,
  output logic [N_VOICES-1:0]    note_done_mask,
  output logic                   new_sample_generated,
  output logic [SAMPLE_W-1:0]    sample_out
);

  localparam int SUM_W = SAMPLE_W + $clog2(N_VOICES);

  // Frame contract: new_frame is a one-cycle request with no back-pressure. It is
  // accepted only when the pipeline is idle; new_sample_generated pulses three
  // cycles later and sample_out holds its value until the next pulse.
  logic                              frame_accept;
  logic                              vs_vld_q, sum_vld_q, strobe_q;
  logic signed [SUM_W-1:0]           sum_q, sum_d;
  logic [SAMPLE_W-1:0]               sample_q, sample_d;
  logic [N_VOICES-1:0][SAMPLE_W-1:0] voice_sample;

  assign frame_accept = new_frame && !(vs_vld_q || sum_vld_q);

  for (genvar i = 0; i < N_VOICES; i++) begin : g_voice
    voice_channel #(
      .SAMPLE_W (SAMPLE_W),
      .PHASE_W  (PHASE_W),
      .DUR_W    (DUR_W)
    ) u_voice (
      .clk           (clk),
      .reset         (reset),
      .play_enable   (play_enable),
      .beat          (beat),
      .frame_accept  (frame_accept),
      .load          (note_load && (note_voice == VOICE_IDX_W'(i))),
      .load_step     (note_step),
      .load_wave     (note_wave),
      .load_duration (note_duration),
      .active        (voice_active[i]),
      .done          (note_done_mask[i]),
      .sample        (voice_sample[i])
    );
  end

  always_comb begin
    sum_d = sum_q;
    if (vs_vld_q) begin
      sum_d = '0;
      for (int i = 0; i < N_VOICES; i++) begin
        sum_d = sum_d + SUM_W'($signed(voice_sample[i]));
      end
    end
  end

`ifdef POLY_PLAYER_SATURATE_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(square_amp(SAMPLE_W));
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    sample_d = sample_q;
    if (sum_vld_q) begin
      if (sum_q > SAT_MAX) begin
        sample_d = SAMPLE_W'(SAT_MAX);
      end else if (sum_q < SAT_MIN) begin
        sample_d = SAMPLE_W'(SAT_MIN);
      end else begin
        sample_d = SAMPLE_W'(sum_q);
      end
    end
  end
`else
  // Dividing by the voice count keeps any full-scale mix in range.
  always_comb begin
    sample_d = sample_q;
    if (sum_vld_q) begin
      sample_d = SAMPLE_W'(sum_q >>> $clog2(N_VOICES));
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_vld_q  <= 1'b0;
      sum_vld_q <= 1'b0;
      strobe_q  <= 1'b0;
      sum_q     <= '0;
      sample_q  <= '0;
    end else begin
      vs_vld_q  <= frame_accept;
      sum_vld_q <= vs_vld_q;
      strobe_q  <= sum_vld_q;
      sum_q     <= sum_d;
      sample_q  <= sample_d;
    end
  end

  assign new_sample_generated = strobe_q;
  assign sample_out           = sample_q;

endmodule

// File: tb/tb_poly_note_player.sv
// Self-checking bench for poly_note_player: directed scenarios plus a random run
// against a voice-level arithmetic model.
module tb_poly_note_player;

  localparam int NV = 4;
  localparam int SW = 16;
  localparam int PW = 20;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          play_enable = 1'b0;
  logic          beat = 1'b0;
  logic          new_frame = 1'b0;
  logic          note_load = 1'b0;
  logic [1:0]    note_voice = '0;
  logic [PW-1:0] note_step = '0;
  logic          note_wave = 1'b0;
  logic [DW-1:0] note_duration = '0;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] note_done_mask;
  logic          new_sample_generated;
  logic [SW-1:0] sample_out;

  poly_note_player #(
    .N_VOICES (NV),
    .SAMPLE_W (SW),
    .PHASE_W  (PW),
    .DUR_W    (DW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .beat                 (beat),
    .new_frame            (new_frame),
    .note_load            (note_load),
    .note_voice           (note_voice),
    .note_step            (note_step),
    .note_wave            (note_wave),
    .note_duration        (note_duration),
    .voice_active         (voice_active),
    .note_done_mask       (note_done_mask),
    .new_sample_generated (new_sample_generated),
    .sample_out           (sample_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  int unsigned   m_ph[NV];
  int unsigned   m_step[NV];
  bit            m_wave[NV];
  int            m_rem[NV];
  logic [NV-1:0] m_act;
  logic [NV-1:0] m_done;
  int            m_busy;
  logic [SW-1:0] exp_q[$];
  int            exp_at[$];

  function automatic int voice_val(int v);
    int top;
    top = int'(m_ph[v] >> (PW - SW));
    if (m_wave[v]) return (top < 32768) ? 32767 : -32767;
    return top - 32768;
  endfunction

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_ph[v] = 0; m_step[v] = 0; m_wave[v] = 0; m_rem[v] = 0;
    end
    m_act = '0; m_done = '0; m_busy = 0;
    exp_q.delete(); exp_at.delete();
  endtask

  task automatic model_edge();
    bit acc;
    int s;
    m_done = '0;
    if (reset) begin
      model_clear();
      return;
    end
    acc = new_frame && (m_busy == 0);
    if (acc) begin
      s = 0;
      for (int v = 0; v < NV; v++) if (m_act[v] && play_enable) s += voice_val(v);
`ifdef POLY_PLAYER_SATURATE_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`else
      s = s >>> 2;
`endif
      exp_q.push_back(SW'(s));
      exp_at.push_back(cyc + 3);
      m_busy = 2;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    for (int v = 0; v < NV; v++) begin
      if (note_load && int'(note_voice) == v) begin
        m_step[v] = note_step; m_wave[v] = note_wave; m_rem[v] = note_duration;
        m_ph[v] = 0; m_act[v] = (note_duration != 0);
      end else if (m_act[v] && play_enable) begin
        if (acc) m_ph[v] = (m_ph[v] + m_step[v]) % (1 << PW);
        if (beat) begin
          m_rem[v]--;
          if (m_rem[v] == 0) begin
            m_act[v] = 1'b0; m_ph[v] = 0; m_done[v] = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    beat = 1'b0; new_frame = 1'b0; note_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; play_enable = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic load_note(input int v, input int step, input bit wave, input int dur);
    note_load = 1'b1; note_voice = 2'(v); note_step = PW'(step);
    note_wave = wave; note_duration = DW'(dur);
  endtask

  task automatic pop_exp(output logic [SW-1:0] e);
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (exp_at.size() > 0) void'(exp_at.pop_front());
  endtask

  // Requests one frame; lat is cycles after c+1 until the strobe, -1 on timeout.
  task automatic do_frame(output int lat, output logic [SW-1:0] s);
    new_frame = 1'b1;
    tick();
    lat = -1; s = '0;
    for (int k = 0; k < 8; k++) begin
      if (new_sample_generated) begin
        lat = k; s = sample_out;
        break;
      end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (voice_active !== 4'b0) $display("FAIL reset_active: got %b want 0000", voice_active); else n_pass++;
    n_checks++; if (note_done_mask !== 4'b0) $display("FAIL reset_done: got %b want 0000", note_done_mask); else n_pass++;
    n_checks++; if (new_sample_generated !== 1'b0) $display("FAIL reset_strobe: got %b want 0", new_sample_generated); else n_pass++;
    n_checks++; if (sample_out !== 16'd0) $display("FAIL reset_sample: got %0d want 0", $signed(sample_out)); else n_pass++;
  endtask

  task automatic test_frame_timing();
    int lat, cnt;
    logic [SW-1:0] s, e;
    do_reset();
    do_frame(lat, s);
    pop_exp(e);
    n_checks++; if (lat !== 2) $display("FAIL idle_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (s !== 16'd0) $display("FAIL idle_sample: got %0d want 0", $signed(s)); else n_pass++;
    new_frame = 1'b1; tick();
    new_frame = 1'b1; tick();
    tick();
    n_checks++; if (new_sample_generated !== 1'b1) $display("FAIL busy_first_strobe: got %b want 1", new_sample_generated); else n_pass++;
    pop_exp(e);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (new_sample_generated) cnt++;
    end
    n_checks++; if (cnt !== 0) $display("FAIL busy_ignored: got %0d extra strobes want 0", cnt); else n_pass++;
  endtask

  task automatic test_saw();
    int lat;
    logic [SW-1:0] s, e;
    do_reset();
    load_note(0, 'h01000, 1'b0, 3);
    tick();
    n_checks++; if (voice_active !== 4'b0001) $display("FAIL saw_active: got %b want 0001", voice_active); else n_pass++;
    do_frame(lat, s); pop_exp(e);
    n_checks++; if (s !== e) $display("FAIL saw_f1_model: got %0d want %0d", $signed(s), $signed(e)); else n_pass++;
`ifndef POLY_PLAYER_SATURATE_EN
    n_checks++; if ($signed(s) !== -16'sd8192) $display("FAIL saw_f1: got %0d want -8192", $signed(s)); else n_pass++;
`endif
    do_frame(lat, s); pop_exp(e);
    n_checks++; if (s !== e) $display("FAIL saw_f2_model: got %0d want %0d", $signed(s), $signed(e)); else n_pass++;
`ifndef POLY_PLAYER_SATURATE_EN
    n_checks++; if ($signed(s) !== -16'sd8128) $display("FAIL saw_f2: got %0d want -8128", $signed(s)); else n_pass++;
`endif
  endtask

  task automatic test_expiry();
    int lat;
    logic [SW-1:0] s, e;
    do_reset();
    load_note(0, 'h02000, 1'b0, 2);
    tick();
    beat = 1'b1; tick();
    n_checks++; if (voice_active[0] !== 1'b1 || note_done_mask !== 4'b0) $display("FAIL exp_beat1: got act=%b done=%b want 1/0000", voice_active[0], note_done_mask); else n_pass++;
    beat = 1'b1; tick();
    n_checks++; if (voice_active[0] !== 1'b0) $display("FAIL exp_active: got %b want 0", voice_active[0]); else n_pass++;
    n_checks++; if (note_done_mask !== 4'b0001) $display("FAIL exp_done: got %b want 0001", note_done_mask); else n_pass++;
    tick();
    n_checks++; if (note_done_mask !== 4'b0000) $display("FAIL exp_done_pulse: got %b want 0000", note_done_mask); else n_pass++;
    do_frame(lat, s); pop_exp(e);
    n_checks++; if (s !== 16'd0 || e !== 16'd0) $display("FAIL exp_silent: got %0d want 0", $signed(s)); else n_pass++;
  endtask

  task automatic test_square_mix();
    int lat;
    logic [SW-1:0] s, e;
    do_reset();
    load_note(0, 0, 1'b1, 10); tick();
    load_note(1, 0, 1'b1, 10); tick();
    do_frame(lat, s); pop_exp(e);
    n_checks++; if (s !== e) $display("FAIL square_model: got %0d want %0d", $signed(s), $signed(e)); else n_pass++;
`ifdef POLY_PLAYER_SATURATE_EN
    n_checks++; if (s !== 16'd32767) $display("FAIL square_mix: got %0d want 32767", $signed(s)); else n_pass++;
`else
    n_checks++; if (s !== 16'd16383) $display("FAIL square_mix: got %0d want 16383", $signed(s)); else n_pass++;
`endif
  endtask

  task automatic test_load_beat();
    do_reset();
    load_note(2, 'h00400, 1'b0, 1); tick();
    n_checks++; if (voice_active !== 4'b0100) $display("FAIL lb_active: got %b want 0100", voice_active); else n_pass++;
    load_note(2, 'h00400, 1'b1, 5); beat = 1'b1; tick();
    n_checks++; if (note_done_mask !== 4'b0 || voice_active[2] !== 1'b1) $display("FAIL lb_same_cycle: got done=%b act=%b want 0000/1", note_done_mask, voice_active[2]); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      beat = 1'b1; tick();
    end
    n_checks++; if (note_done_mask !== 4'b0 || voice_active[2] !== 1'b1) $display("FAIL lb_four_beats: got done=%b act=%b want 0000/1", note_done_mask, voice_active[2]); else n_pass++;
    beat = 1'b1; tick();
    n_checks++; if (note_done_mask !== 4'b0100 || voice_active[2] !== 1'b0) $display("FAIL lb_fifth_beat: got done=%b act=%b want 0100/0", note_done_mask, voice_active[2]); else n_pass++;
  endtask

  task automatic test_pause();
    int lat;
    logic [SW-1:0] s, e;
    do_reset();
    load_note(0, 'h03000, 1'b0, 30); tick();
    do_frame(lat, s); pop_exp(e);
    do_frame(lat, s); pop_exp(e);
    n_checks++; if (s !== e) $display("FAIL pause_pre: got %0d want %0d", $signed(s), $signed(e)); else n_pass++;
    play_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_frame(lat, s); pop_exp(e);
      n_checks++; if (lat !== 2 || s !== 16'd0) $display("FAIL pause_frame%0d: got lat=%0d sample=%0d want 2/0", k, lat, $signed(s)); else n_pass++;
    end
    play_enable = 1'b1;
    do_frame(lat, s); pop_exp(e);
    n_checks++; if (s !== e) $display("FAIL pause_resume_model: got %0d want %0d", $signed(s), $signed(e)); else n_pass++;
`ifndef POLY_PLAYER_SATURATE_EN
    n_checks++; if ($signed(s) !== -16'sd7808) $display("FAIL pause_resume: got %0d want -7808", $signed(s)); else n_pass++;
`endif
  endtask

  task automatic test_reset_cancel();
    int cnt;
    do_reset();
    new_frame = 1'b1; tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (new_sample_generated) cnt++;
    end
    n_checks++; if (cnt !== 0) $display("FAIL reset_cancel: got %0d strobes want 0", cnt); else n_pass++;
  endtask

  task automatic test_random();
    bit exp_strobe;
    logic [SW-1:0] e;
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      if (i < 590) begin
        play_enable = ($urandom_range(0, 9) != 0);
        beat        = ($urandom_range(0, 3) == 0);
        new_frame   = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 3) == 0) begin
          load_note($urandom_range(0, 3), $urandom_range(0, 'hFFFFF), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
        end
      end else begin
        play_enable = 1'b1;
      end
      tick();
      exp_strobe = (exp_at.size() > 0) && (exp_at[0] == cyc);
      n_checks++; if (voice_active !== m_act) $display("FAIL rnd_active@%0d: got %b want %b", cyc, voice_active, m_act); else n_pass++;
      n_checks++; if (note_done_mask !== m_done) $display("FAIL rnd_done@%0d: got %b want %b", cyc, note_done_mask, m_done); else n_pass++;
      n_checks++; if (new_sample_generated !== exp_strobe) $display("FAIL rnd_strobe@%0d: got %b want %b", cyc, new_sample_generated, exp_strobe); else n_pass++;
      if (exp_strobe) begin
        pop_exp(e);
        n_checks++; if (sample_out !== e) $display("FAIL rnd_sample@%0d: got %0d want %0d", cyc, $signed(sample_out), $signed(e)); else n_pass++;
      end
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    model_clear();
    test_reset();
    test_frame_timing();
    test_saw();
    test_expiry();
    test_square_mix();
    test_load_beat();
    test_pause();
    test_reset_cancel();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/poly_note_player.md
# poly_note_player

Parametrised polyphonic successor to the single-voice note player: N independent voices, each with its own phase accumulator, selectable waveform and beat-counted duration. Each sample request produces one mixed sample. Sits between the song reader/keypad control logic and the codec sample interface. Keeps the `new_frame` → `new_sample_generated` / `sample_out` contract of the existing player.

## Interface
Parameters:
- `N_VOICES`, 4, number of voices; power of two, 1..8
- `SAMPLE_W`, 16, signed output sample width
- `PHASE_W`, 20, phase accumulator width; must be ≥ `SAMPLE_W`
- `DUR_W`, 6, note duration width, in beats

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `play_enable`  in  1  1 = run, 0 = pause
- `beat`  in  1  one-cycle beat strobe
- `new_frame`  in  1  one-cycle sample request
- `note_load`  in  1  load a note into `note_voice`
- `note_voice`  in  $clog2(N_VOICES) (min 1)  target voice
- `note_step`  in  PHASE_W  phase increment per sample
- `note_wave`  in  1  0 = sawtooth, 1 = square
- `note_duration`  in  DUR_W  beats; 0 = silence the voice now
- `voice_active`  out  N_VOICES  per-voice sounding flag
- `note_done_mask`  out  N_VOICES  one-cycle pulse per voice that expired
- `new_sample_generated`  out  1  one-cycle strobe; `sample_out` updated
- `sample_out`  out  SAMPLE_W  signed mixed sample; held between strobes

## Operation
- **Reset:** all phases, durations, `voice_active`, `note_done_mask`, `new_sample_generated` and `sample_out` are 0. Pipeline is idle.
- **Load:** `note_load` sets the voice's step, wave and remaining count to `note_duration`, and clears its phase to 0.
  - If `note_duration` is nonzero, the voice becomes active.
  - If it is 0, the voice goes inactive immediately, with no done pulse.
  - A load into an active voice restarts that voice.
- **Beat:** on `beat` with `play_enable` high, every active voice decrements its remaining count. A voice whose count goes 1→0:
  - clears `voice_active`;
  - clears its phase;
  - sets its bit in `note_done_mask` for exactly one cycle.
  - Several voices may expire together.
- **Load and beat in the same cycle on the same voice:** the load wins; no decrement and no done pulse for that voice. Other voices decrement normally.
- **Waveform,** taken from the top `SAMPLE_W` bits `p` of the phase:
  - saw = `{~p[MSB], p[MSB-1:0]}` as two's complement;
  - square = +(2^(SAMPLE_W-1)−1) when `p[MSB]`=0, otherwise −(2^(SAMPLE_W-1)−1).
  - An inactive voice contributes 0.
- **Sample generation:** an accepted `new_frame` samples every voice from its current phase, then advances the phase by its step, modulo 2^PHASE_W (wrap allowed).
- **Pause:** with `play_enable` low, phases and durations are frozen. `new_frame` is still served: strobe as normal, `sample_out` = 0.
- **Mixing:** voice samples are summed at width SAMPLE_W+$clog2(N_VOICES), then reduced per Configuration.

## Timing
- `new_frame` in cycle c produces the following, with `sample_out` holding until the next strobe:
  - end of c: voice samples registered and phases advanced;
  - end of c+1: sum registered;
  - end of c+2: output registered;
  - `new_sample_generated` high in cycle c+3.
- The pipeline is busy for cycles c+1..c+2. A `new_frame` in those cycles is ignored and is not queued.
- `voice_active` and `note_done_mask` update on the edge following `note_load` or `beat`.
- A `reset` asserted mid-pipeline cancels any pending strobe.

## Configuration
- `POLY_PLAYER_SATURATE_EN`
  - **Defined:** the sum is saturated to [−2^(SAMPLE_W-1), 2^(SAMPLE_W-1)−1], with no attenuation.
  - **Undefined:** the sum is arithmetically shifted right by $clog2(N_VOICES). Overflow is impossible.

## Structure
- Package `poly_player_pkg`:
  - wave-select constants `WAVE_SAW` = 0, `WAVE_SQUARE` = 1;
  - a `VOICE_IDX_W` helper;
  - the square amplitude constant function.
- Sub-module `voice_channel`, instantiated N_VOICES times. It contains the phase accumulator, duration counter, load/beat priority and waveform stage.
- The top level holds the adder tree, reduction, output register and strobe.

## Test plan
All scenarios use N_VOICES=4, SAMPLE_W=16, PHASE_W=20, DUR_W=6.

1. Reset, then `new_frame` with no notes loaded → `new_sample_generated` exactly in cycle c+3, `sample_out` = 0. `new_frame` repeated at c+1 → no second strobe.
2. Load voice 0: saw, step 0x01000, duration 3, play (macro undefined). Frame 1 → −8192 (−32768>>2). Frame 2 → −8128 (0x8100>>2).
3. Voice 0 with duration 2 → after the second `beat`, `voice_active[0]`=0 and `note_done_mask`=4'b0001 for one cycle. The next frame gives 0.
4. Voices 0 and 1 square at phase 0 → sum 65534. Macro defined: 32767. Undefined: 16383.
5. Voice 2 active with 1 beat left; load duration 5 in the same cycle as `beat` → no done pulse, `voice_active[2]` stays 1, and expiry occurs after 5 further beats.
6. Mid-note, drop `play_enable` for 3 frames → strobes continue with `sample_out`=0. On resume, the sample equals the one that would have followed the pre-pause frame (phase frozen).
